// File: rtl/dca_lsu_sched_pkg.sv
// Shared types, AXI constants and helpers for the LSU store scheduler.
package dca_lsu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // txn_info = {last_row, beats}: beats in the low bits, last_row directly above
  localparam int TXN_BEATS_LSB = 0;

  function automatic int txn_last_row_pos(input int bw_beats);
    return bw_beats;
  endfunction

  function automatic logic [2:0] axi_awsize(input int bw_axi_data);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (bw_axi_data / 8)) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/dca_lsu_outstanding_counter.sv
// Up/down count of AW bursts still waiting for their B response, with full flag.
module dca_lsu_outstanding_counter
  import dca_lsu_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rstnn,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic full
);

  localparam int BW_CNT = $clog2(MAX_OUTSTANDING + 1);

  logic [BW_CNT-1:0] count_q;

  // Simultaneous inc and dec cancel; a stray dec at zero is ignored
  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      count_q <= '0;
    end else if (inc && !dec) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign full = (count_q == BW_CNT'(MAX_OUTSTANDING));

endmodule

// File: rtl/dca_lsu_store_scheduler.sv
// Splits one matrix store command into per-row AXI AW bursts and datapath tokens.
// Optional: DCA_LSU_STORE_SCHED_ERROR_ABORT_EN stops issue after the first error response.
module dca_lsu_store_scheduler
  import dca_lsu_sched_pkg::*;
#(
  parameter int BW_ADDR         = 32,
  parameter int BW_AXI_DATA     = 32,
  parameter int BW_ROW_CNT      = 16,
  parameter int BW_BEATS        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  clear,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BW_ADDR-1:0]    cmd_base_addr,
  input  logic [BW_ROW_CNT-1:0] cmd_num_rows,
  input  logic [BW_ADDR-1:0]    cmd_stride,
  input  logic [BW_BEATS-1:0]   cmd_beats,
  output logic                  txn_valid,
  input  logic                  txn_ready,
  output logic [BW_BEATS:0]     txn_info,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [BW_ADDR-1:0]    awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int LAST_POS = txn_last_row_pos(BW_BEATS);

  sched_state_e state_q, state_d;

  logic [BW_ADDR-1:0]    addr_q;
  logic [BW_ADDR-1:0]    stride_q;
  logic [BW_ROW_CNT-1:0] num_rows_q;
  logic [BW_ROW_CNT-1:0] aw_cnt;
  logic [BW_ROW_CNT-1:0] txn_cnt;
  logic [BW_ROW_CNT-1:0] b_cnt;
  logic [BW_ROW_CNT-1:0] b_cnt_next;
  logic [BW_BEATS-1:0]   beats_q;
  logic [BW_BEATS-1:0]   beats_m1;
  logic                  error_q;
  logic                  bready_q;

  logic accept;
  logic aw_fire;
  logic txn_fire;
  logic b_fire;
  logic b_err;
  logic aw_want;
  logic txn_want;
  logic out_full;
  logic issue_stop;
  logic issue_done;
  logic drain_complete;
  logic txn_last;

  // bready_q doubles as "out of reset"; a soft clear keeps draining B responses
  always_ff @(posedge clk) begin
    if (!rstnn) bready_q <= 1'b0;
    else        bready_q <= 1'b1;
  end

  assign cmd_ready  = (state_q == ST_IDLE) && bready_q;
  assign accept     = cmd_valid && cmd_ready;
  assign b_fire     = bvalid && bready_q && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign b_err      = b_fire && (bresp != AXI_RESP_OKAY);
  assign b_cnt_next = b_cnt + BW_ROW_CNT'(b_fire);

  assign aw_want  = (state_q == ST_ISSUE) && (aw_cnt < num_rows_q) && !out_full;
  assign txn_want = (state_q == ST_ISSUE) && (txn_cnt < num_rows_q) && (txn_cnt <= aw_cnt);

  assign aw_fire  = awvalid && awready;
  assign txn_fire = txn_valid && txn_ready;

`ifdef DCA_LSU_STORE_SCHED_ERROR_ABORT_EN
  logic abort_q;
  logic aw_hold_q;
  logic txn_hold_q;

  // After an error only requests already on the bus may complete their handshake
  assign awvalid    = aw_want && (!abort_q || aw_hold_q);
  assign txn_valid  = txn_want && (!abort_q || txn_hold_q);
  assign issue_stop = abort_q && !awvalid && !txn_valid;

  always_ff @(posedge clk) begin
    if (!rstnn || clear || accept) begin
      abort_q    <= 1'b0;
      aw_hold_q  <= 1'b0;
      txn_hold_q <= 1'b0;
    end else begin
      if (b_err) abort_q <= 1'b1;
      aw_hold_q  <= awvalid && !awready;
      txn_hold_q <= txn_valid && !txn_ready;
    end
  end
`else
  assign awvalid    = aw_want;
  assign txn_valid  = txn_want;
  assign issue_stop = 1'b0;
`endif

  // Every issued burst must be answered; aw_cnt equals num_rows unless issue was aborted
  assign issue_done     = ((aw_cnt == num_rows_q) && (txn_cnt == num_rows_q)) || issue_stop;
  assign drain_complete = (b_cnt_next >= aw_cnt);

  dca_lsu_outstanding_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk  (clk),
    .rstnn(rstnn),
    .clear(clear || accept),
    .inc  (aw_fire),
    .dec  (b_fire),
    .full (out_full)
  );

  always_ff @(posedge clk) begin
    if (!rstnn || clear) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // A null command passes through DRAIN so done lands two cycles after acceptance
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (cmd_num_rows == '0) ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_done) state_d = drain_complete ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_complete) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      addr_q     <= '0;
      stride_q   <= '0;
      num_rows_q <= '0;
      beats_q    <= '0;
      aw_cnt     <= '0;
      txn_cnt    <= '0;
      b_cnt      <= '0;
      error_q    <= 1'b0;
    end else if (accept) begin
      addr_q     <= cmd_base_addr;
      stride_q   <= cmd_stride;
      num_rows_q <= cmd_num_rows;
      beats_q    <= cmd_beats;
      aw_cnt     <= '0;
      txn_cnt    <= '0;
      b_cnt      <= '0;
      error_q    <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_cnt <= aw_cnt + 1'b1;
        addr_q <= addr_q + stride_q;
      end
      if (txn_fire) txn_cnt <= txn_cnt + 1'b1;
      if (b_fire)   b_cnt   <= b_cnt_next;
      if (b_err)    error_q <= 1'b1;
    end
  end

  assign txn_last = (txn_cnt == (num_rows_q - 1'b1));

  always_comb begin
    txn_info = '0;
    txn_info[TXN_BEATS_LSB +: BW_BEATS] = beats_q;
    txn_info[LAST_POS] = txn_last;
  end

  assign beats_m1 = beats_q - 1'b1;
  assign awaddr   = addr_q;
  assign awlen    = 8'(beats_m1);
  assign awsize   = axi_awsize(BW_AXI_DATA);
  assign awburst  = AXI_BURST_INCR;
  assign bready   = bready_q;
  assign busy     = (state_q != ST_IDLE);
  assign error    = error_q;

endmodule

// File: tb/tb_dca_lsu_store_scheduler.sv
// Directed self-checking bench for dca_lsu_store_scheduler (default parameters).
module tb_dca_lsu_store_scheduler;

  logic        clk;
  logic        rstnn;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_base_addr;
  logic [15:0] cmd_num_rows;
  logic [31:0] cmd_stride;
  logic [7:0]  cmd_beats;
  logic        txn_valid;
  logic        txn_ready;
  logic [8:0]  txn_info;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        busy;
  logic        done;
  logic        error;

  int n_pass, n_total, cyc, accept_cyc;
  int done_cnt, done_cyc, last_b_cyc, b_seen, err_idx, b_delay;
  int aw_valid_seen, txn_valid_seen;
  bit auto_b;
  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic [8:0]  txn_log[$];
  int          b_due[$];

  dca_lsu_store_scheduler dut (
    .clk          (clk),
    .rstnn        (rstnn),
    .clear        (clear),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_num_rows (cmd_num_rows),
    .cmd_stride   (cmd_stride),
    .cmd_beats    (cmd_beats),
    .txn_valid    (txn_valid),
    .txn_ready    (txn_ready),
    .txn_info     (txn_info),
    .awvalid      (awvalid),
    .awready      (awready),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awsize       (awsize),
    .awburst      (awburst),
    .bvalid       (bvalid),
    .bready       (bready),
    .bresp        (bresp),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic reset_logs();
    aw_addr_log.delete();
    aw_len_log.delete();
    txn_log.delete();
    b_due.delete();
    done_cnt = 0; done_cyc = -1; last_b_cyc = -1; b_seen = 0;
    aw_valid_seen = 0; txn_valid_seen = 0;
  endtask

  // One clock: optional auto B responder, negedge monitor, then step past posedge
  task automatic run_cycle();
    if (auto_b) begin
      if (b_due.size() > 0 && b_due[0] <= cyc) begin
        bvalid = 1'b1;
        bresp  = (b_seen == err_idx) ? 2'b10 : 2'b00;
      end else begin
        bvalid = 1'b0;
        bresp  = 2'b00;
      end
    end
    @(negedge clk);
    if (awvalid) aw_valid_seen++;
    if (txn_valid) txn_valid_seen++;
    if (awvalid && awready) begin
      aw_addr_log.push_back(awaddr);
      aw_len_log.push_back(awlen);
      if (auto_b) b_due.push_back(cyc + b_delay);
    end
    if (txn_valid && txn_ready) txn_log.push_back(txn_info);
    if (bvalid && bready) begin
      b_seen++;
      last_b_cyc = cyc;
      if (auto_b && b_due.size() > 0) void'(b_due.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input logic [31:0] base, input logic [15:0] rows,
                          input logic [31:0] stride, input logic [7:0] beats);
    cmd_base_addr = base;
    cmd_num_rows  = rows;
    cmd_stride    = stride;
    cmd_beats     = beats;
    cmd_valid     = 1'b1;
    accept_cyc    = cyc;
    run_cycle();
    cmd_valid     = 1'b0;
  endtask

  task automatic run_until_done(input int max_cycles);
    for (int i = 0; i < max_cycles && done_cnt == 0; i++) run_cycle();
  endtask

  task automatic test_reset();
    rstnn = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bready !== 1'b0) $display("[TB] FAIL reset_bready: got %0h expected 0", bready); else n_pass++;
    n_total++; if (awvalid !== 1'b0) $display("[TB] FAIL reset_awvalid: got %0h expected 0", awvalid); else n_pass++;
    n_total++; if (txn_valid !== 1'b0) $display("[TB] FAIL reset_txn_valid: got %0h expected 0", txn_valid); else n_pass++;
    rstnn = 1'b1;
    @(posedge clk); #1;
    n_total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %0h expected 1", cmd_ready); else n_pass++;
    n_total++; if (bready !== 1'b1) $display("[TB] FAIL reset_bready_after: got %0h expected 1", bready); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b000) $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, error}); else n_pass++;
    n_total++; if (awsize !== 3'd2) $display("[TB] FAIL awsize: got %0d expected 2", awsize); else n_pass++;
    n_total++; if (awburst !== 2'b01) $display("[TB] FAIL awburst: got %0d expected 1", awburst); else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] got_addr;
    logic [7:0]  got_len;
    logic [8:0]  got_txn;
    reset_logs();
    auto_b = 1'b1; b_delay = 2; err_idx = -1;
    awready = 1'b1; txn_ready = 1'b1;
    send_cmd(32'h0000_1000, 16'd4, 32'h40, 8'd8);
    n_total++; if (awvalid !== 1'b1) $display("[TB] FAIL basic_first_awvalid: got %0h expected 1", awvalid); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy: got %0h expected 1", busy); else n_pass++;
    run_until_done(60);
    repeat (4) run_cycle();
    n_total++; if (aw_addr_log.size() != 4) $display("[TB] FAIL basic_aw_count: got %0d expected 4", aw_addr_log.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got_addr = (i < aw_addr_log.size()) ? aw_addr_log[i] : 32'hDEAD_BEEF;
      got_len  = (i < aw_len_log.size()) ? aw_len_log[i] : 8'hEE;
      got_txn  = (i < txn_log.size()) ? txn_log[i] : 9'h1FF;
      n_total++; if (got_addr !== 32'h1000 + 32'(i) * 32'h40) $display("[TB] FAIL basic_awaddr%0d: got %h expected %h", i, got_addr, 32'h1000 + 32'(i) * 32'h40); else n_pass++;
      n_total++; if (got_len !== 8'd7) $display("[TB] FAIL basic_awlen%0d: got %0d expected 7", i, got_len); else n_pass++;
      n_total++; if (got_txn !== ((i == 3) ? 9'h108 : 9'h008)) $display("[TB] FAIL basic_txn_info%0d: got %h expected %h", i, got_txn, (i == 3) ? 9'h108 : 9'h008); else n_pass++;
    end
    n_total++; if (done_cnt != 1) $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc != last_b_cyc + 1) $display("[TB] FAIL basic_done_latency: got cycle %0d expected %0d", done_cyc, last_b_cyc + 1); else n_pass++;
    n_total++; if (error !== 1'b0) $display("[TB] FAIL basic_error: got %0h expected 0", error); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_after: got %0h expected 0", busy); else n_pass++;
  endtask

  task automatic test_outstanding();
    reset_logs();
    auto_b = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    awready = 1'b1; txn_ready = 1'b1;
    send_cmd(32'h0000_8000, 16'd8, 32'h80, 8'd4);
    repeat (10) run_cycle();
    n_total++; if (aw_addr_log.size() != 4) $display("[TB] FAIL outst_aw_limit: got %0d expected 4", aw_addr_log.size()); else n_pass++;
    n_total++; if (awvalid !== 1'b0) $display("[TB] FAIL outst_awvalid_low: got %0h expected 0", awvalid); else n_pass++;
    n_total++; if (txn_log.size() != 5) $display("[TB] FAIL outst_txn_lead: got %0d expected 5", txn_log.size()); else n_pass++;
    bvalid = 1'b1;
    run_cycle();
    bvalid = 1'b0;
    repeat (5) run_cycle();
    n_total++; if (aw_addr_log.size() != 5) $display("[TB] FAIL outst_one_more_aw: got %0d expected 5", aw_addr_log.size()); else n_pass++;
    n_total++; if (awvalid !== 1'b0) $display("[TB] FAIL outst_awvalid_low2: got %0h expected 0", awvalid); else n_pass++;
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      bvalid = (b_seen < aw_addr_log.size());
      run_cycle();
    end
    bvalid = 1'b0;
    n_total++; if (aw_addr_log.size() != 8) $display("[TB] FAIL outst_aw_total: got %0d expected 8", aw_addr_log.size()); else n_pass++;
    n_total++; if (done_cnt != 1) $display("[TB] FAIL outst_done: got %0d expected 1", done_cnt); else n_pass++;
    n_total++; if (txn_log.size() != 8 || txn_log[7] !== 9'h104) $display("[TB] FAIL outst_last_txn: got count %0d expected 8 with last 104", txn_log.size()); else n_pass++;
  endtask

  task automatic test_null();
    reset_logs();
    auto_b = 1'b1; b_delay = 2; err_idx = -1;
    send_cmd(32'h0000_3000, 16'd0, 32'h40, 8'd4);
    n_total++; if (busy !== 1'b1) $display("[TB] FAIL null_busy: got %0h expected 1", busy); else n_pass++;
    run_until_done(10);
    n_total++; if (done_cyc != accept_cyc + 2) $display("[TB] FAIL null_done_latency: got cycle %0d expected %0d", done_cyc, accept_cyc + 2); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("[TB] FAIL null_busy_after: got %0h expected 0", busy); else n_pass++;
    n_total++; if (aw_valid_seen + txn_valid_seen != 0) $display("[TB] FAIL null_no_issue: got %0d valid cycles expected 0", aw_valid_seen + txn_valid_seen); else n_pass++;
  endtask

  task automatic test_error(input logic [15:0] rows, input int delay, input int exp_aw);
    reset_logs();
    auto_b = 1'b1; b_delay = delay; err_idx = 1;
    awready = 1'b1; txn_ready = 1'b1;
    send_cmd(32'h0000_2000, rows, 32'h10, 8'd2);
    run_until_done(80);
    repeat (3) run_cycle();
    n_total++; if (aw_addr_log.size() != exp_aw) $display("[TB] FAIL error_aw_count_r%0d: got %0d expected %0d", rows, aw_addr_log.size(), exp_aw); else n_pass++;
    n_total++; if (txn_log.size() != exp_aw) $display("[TB] FAIL error_txn_count_r%0d: got %0d expected %0d", rows, txn_log.size(), exp_aw); else n_pass++;
    n_total++; if (error !== 1'b1) $display("[TB] FAIL error_sticky_r%0d: got %0h expected 1", rows, error); else n_pass++;
    n_total++; if (done_cnt != 1) $display("[TB] FAIL error_done_r%0d: got %0d expected 1", rows, done_cnt); else n_pass++;
    err_idx = -1;
  endtask

  task automatic test_wrap();
    reset_logs();
    auto_b = 1'b1; b_delay = 2; err_idx = -1;
    send_cmd(32'hFFFF_FFC0, 16'd2, 32'h40, 8'd1);
    run_until_done(40);
    n_total++; if (aw_addr_log.size() != 2 || aw_addr_log[0] !== 32'hFFFF_FFC0) $display("[TB] FAIL wrap_addr0: got count %0d expected ffffffc0 first", aw_addr_log.size()); else n_pass++;
    n_total++; if (aw_addr_log.size() != 2 || aw_addr_log[1] !== 32'h0000_0000) $display("[TB] FAIL wrap_addr1: got count %0d expected 00000000 second", aw_addr_log.size()); else n_pass++;
    n_total++; if (aw_len_log.size() != 2 || aw_len_log[0] !== 8'd0) $display("[TB] FAIL wrap_awlen: got count %0d expected awlen 0", aw_len_log.size()); else n_pass++;
    n_total++; if (done_cnt != 1) $display("[TB] FAIL wrap_done: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_clear();
    reset_logs();
    auto_b = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    awready = 1'b1; txn_ready = 1'b1;
    send_cmd(32'h0000_4000, 16'd4, 32'h100, 8'd4);
    repeat (2) run_cycle();
    awready = 1'b0;
    run_cycle();
    n_total++; if (aw_addr_log.size() != 2) $display("[TB] FAIL clear_pre_aw: got %0d expected 2", aw_addr_log.size()); else n_pass++;
    clear = 1'b1;
    run_cycle();
    clear = 1'b0;
    n_total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL clear_cmd_ready: got %0h expected 1", cmd_ready); else n_pass++;
    n_total++; if ({busy, awvalid, txn_valid} !== 3'b000) $display("[TB] FAIL clear_idle_outputs: got %b expected 000", {busy, awvalid, txn_valid}); else n_pass++;
    bvalid = 1'b1; bresp = 2'b10;
    repeat (2) run_cycle();
    bvalid = 1'b0; bresp = 2'b00;
    repeat (2) run_cycle();
    n_total++; if (error !== 1'b0) $display("[TB] FAIL clear_late_b_error: got %0h expected 0", error); else n_pass++;
    n_total++; if (done_cnt != 0) $display("[TB] FAIL clear_no_done: got %0d expected 0", done_cnt); else n_pass++;
    n_total++; if (b_seen != 2) $display("[TB] FAIL clear_late_b_consumed: got %0d expected 2", b_seen); else n_pass++;
    reset_logs();
    auto_b = 1'b1; b_delay = 2; err_idx = -1; awready = 1'b1;
    send_cmd(32'h0000_5000, 16'd2, 32'h20, 8'd1);
    run_until_done(40);
    n_total++; if (aw_addr_log.size() != 2 || aw_addr_log[0] !== 32'h5000 || aw_addr_log[1] !== 32'h5020) $display("[TB] FAIL clear_rerun_addr: got count %0d expected 5000,5020", aw_addr_log.size()); else n_pass++;
    n_total++; if (txn_log.size() != 2 || txn_log[0] !== 9'h001 || txn_log[1] !== 9'h101) $display("[TB] FAIL clear_rerun_txn: got count %0d expected 001,101", txn_log.size()); else n_pass++;
    n_total++; if (done_cnt != 1 || error !== 1'b0) $display("[TB] FAIL clear_rerun_done: got done %0d error %0h expected 1 and 0", done_cnt, error); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; accept_cyc = 0;
    rstnn = 1'b0; clear = 1'b0;
    cmd_valid = 1'b0; cmd_base_addr = '0; cmd_num_rows = '0; cmd_stride = '0; cmd_beats = '0;
    txn_ready = 1'b0; awready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    auto_b = 1'b0; b_delay = 2; err_idx = -1;
    reset_logs();
    test_reset();
    test_basic();
    test_outstanding();
    test_null();
    test_error(16'd3, 2, 3);
`ifdef DCA_LSU_STORE_SCHED_ERROR_ABORT_EN
    test_error(16'd6, 1, 3);
`else
    test_error(16'd6, 1, 6);
`endif
    test_wrap();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
